// File: rtl/cpu_bus_pkg.sv
// Shared CPU-bus definitions: DMA state encoding and the fixed register addresses.
package cpu_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HALT,
        ALIGN,
        READ,
        WRITE
    } dma_state_t;

    localparam logic [15:0] ADDR_OAMDMA  = 16'h4014;
    localparam logic [15:0] ADDR_OAMDATA = 16'h2004;

    // Source address never carries into the page byte.
    function automatic logic [15:0] page_addr(input logic [7:0] page, input logic [7:0] idx);
        return {page, idx};
    endfunction

endpackage

// File: rtl/oam_dma_if.sv
// CPU-side bus as seen by the OAM DMA: CPU request lines in, DMA bus-master lines out.
interface oam_dma_if;
    import cpu_bus_pkg::*;

    logic        ce;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_dout;
    logic        cpu_rw;
    logic [7:0]  bus_din;
    logic        dma_rdy;
    logic        dma_active;
    logic [15:0] dma_addr;
    logic        dma_rw;
    logic [7:0]  dma_dout;

    modport master (
        input  ce, cpu_addr, cpu_dout, cpu_rw, bus_din,
        output dma_rdy, dma_active, dma_addr, dma_rw, dma_dout
    );

    modport slave (
        output ce, cpu_addr, cpu_dout, cpu_rw, bus_din,
        input  dma_rdy, dma_active, dma_addr, dma_rw, dma_dout
    );
endinterface

// File: rtl/oam_dma.sv
// OAM DMA: a CPU write of page P to $4014 halts the CPU and copies $P00-$PFF to OAMDATA.
// Stall is 513 ce cycles (514 if the halt lands on a put cycle); ce=0 freezes everything.
module oam_dma
    import cpu_bus_pkg::*;
#(
    parameter logic [15:0] DMA_REG_ADDR  = ADDR_OAMDMA,
    parameter logic [15:0] OAM_DATA_ADDR = ADDR_OAMDATA
) (
    input  logic      clk,
    input  logic      rst,
    oam_dma_if.master bus
);

    dma_state_t state, state_nxt;
    logic       odd;
    logic [7:0] page, page_nxt;
    logic [7:0] idx, idx_nxt;
    logic [7:0] data, data_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            odd   <= 1'b0;
            page  <= 8'h00;
            idx   <= 8'h00;
            data  <= 8'h00;
        end else if (bus.ce) begin
            state <= state_nxt;
            odd   <= ~odd;
            page  <= page_nxt;
            idx   <= idx_nxt;
            data  <= data_nxt;
        end
    end

    // Outputs depend only on registered state, never on the incoming bus.
    always_comb begin
        state_nxt      = state;
        page_nxt       = page;
        idx_nxt        = idx;
        data_nxt       = data;
        bus.dma_rdy    = 1'b1;
        bus.dma_active = 1'b0;
        bus.dma_addr   = 16'h0000;
        bus.dma_rw     = 1'b1;
        bus.dma_dout   = 8'h00;

        case (state)
            IDLE: begin
                if (!bus.cpu_rw && bus.cpu_addr == DMA_REG_ADDR) begin
                    page_nxt  = bus.cpu_dout;
                    idx_nxt   = 8'h00;
                    state_nxt = HALT;
                end
            end
            HALT: begin
                bus.dma_rdy = 1'b0;
                // The CPU only stops on a read; its pending writes must finish first.
                if (bus.cpu_rw) begin
                    state_nxt = odd ? ALIGN : READ;
                end
            end
            ALIGN: begin
                bus.dma_rdy    = 1'b0;
                bus.dma_active = 1'b1;
                bus.dma_addr   = page_addr(page, idx);
                state_nxt      = READ;
            end
            READ: begin
                bus.dma_rdy    = 1'b0;
                bus.dma_active = 1'b1;
                bus.dma_addr   = page_addr(page, idx);
                data_nxt       = bus.bus_din;
                state_nxt      = WRITE;
            end
            WRITE: begin
                bus.dma_rdy    = 1'b0;
                bus.dma_active = 1'b1;
                bus.dma_addr   = OAM_DATA_ADDR;
                bus.dma_rw     = 1'b0;
                bus.dma_dout   = data;
                if (idx == 8'hFF) begin
                    state_nxt = IDLE;
                end else begin
                    idx_nxt   = idx + 8'd1;
                    state_nxt = READ;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_oam_dma.sv
// Directed bench for oam_dma: bus trace and ce-counted stall checked against hand-derived values.
module tb_oam_dma;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    oam_dma_if bus();

    oam_dma #(
        .DMA_REG_ADDR (16'h4014),
        .OAM_DATA_ADDR(16'h2004)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Memory model: each byte is its low address byte xor a per-test mask.
    logic [7:0] din_mask = 8'h5A;
    assign bus.bus_din = bus.dma_addr[7:0] ^ din_mask;

    int tests = 0;
    int fails = 0;
    int ce_total = 0;
    int stall = 0;
    int wr_count = 0;
    int freeze_err = 0;
    bit gaps_on = 1'b0;
    logic [26:0] snap = '0;

    logic [15:0] rec_addr[$];
    logic        rec_rw[$];
    logic [7:0]  rec_dout[$];

    task automatic tick(input logic ce_v);
        bus.ce = ce_v;
        if (ce_v) begin
            ce_total++;
            if (bus.dma_rdy === 1'b0) stall++;
            if (bus.dma_active === 1'b1) begin
                rec_addr.push_back(bus.dma_addr);
                rec_rw.push_back(bus.dma_rw);
                rec_dout.push_back(bus.dma_dout);
                if (bus.dma_rw === 1'b0) wr_count++;
            end
        end
        @(posedge clk);
        #1;
        if (!ce_v && {bus.dma_rdy, bus.dma_active, bus.dma_addr, bus.dma_rw, bus.dma_dout} !== snap)
            freeze_err++;
        snap = {bus.dma_rdy, bus.dma_active, bus.dma_addr, bus.dma_rw, bus.dma_dout};
    endtask

    task automatic step(input logic [15:0] a, input logic [7:0] d, input logic rw);
        int n;
        if (gaps_on) begin
            n = $urandom_range(0, 5);
            for (int i = 0; i < n; i++) begin
                bus.cpu_addr = 16'h4014;
                bus.cpu_dout = 8'hEE;
                bus.cpu_rw   = 1'b0;
                tick(1'b0);
            end
        end
        bus.cpu_addr = a;
        bus.cpu_dout = d;
        bus.cpu_rw   = rw;
        tick(1'b1);
    endtask

    // par: parity of the first halted read cycle (0 = get, 1 = put).
    task automatic run_transfer(input logic [7:0] page, input int par, input int extra,
                                input int stop_wr, input bit retrig, output bit done);
        done = 1'b0;
        rec_addr.delete();
        rec_rw.delete();
        rec_dout.delete();
        stall = 0;
        wr_count = 0;
        if (((ce_total + 1 + extra) % 2) != par) step(16'h8000, 8'h00, 1'b1);
        step(16'h4014, page, 1'b0);
        for (int i = 0; i < extra; i++) step(16'h01FD, 8'h12, 1'b0);
        for (int n = 0; n < 2000; n++) begin
            if (stop_wr != 0 && wr_count >= stop_wr) return;
            if (retrig && wr_count == 255 && bus.dma_active === 1'b1 && bus.dma_rw === 1'b0)
                step(16'h4014, 8'h77, 1'b0);
            else
                step(16'h8000, 8'h00, 1'b1);
            if (bus.dma_rdy === 1'b1) begin
                done = 1'b1;
                return;
            end
        end
    endtask

    // Counts trace entries that differ from the expected read/write sequence.
    task automatic count_txn_errs(input logic [7:0] page, input int align, output int errs);
        logic [7:0] i8;
        int b;
        errs = 0;
        if (rec_addr.size() != 512 + align) begin
            errs = 1000 + rec_addr.size();
            return;
        end
        if (align == 1 && (rec_addr[0] !== {page, 8'h00} || rec_rw[0] !== 1'b1)) errs++;
        for (int i = 0; i < 256; i++) begin
            i8 = i[7:0];
            b  = align + 2 * i;
            if (rec_addr[b] !== {page, i8} || rec_rw[b] !== 1'b1) errs++;
            if (rec_addr[b+1] !== 16'h2004 || rec_rw[b+1] !== 1'b0 ||
                rec_dout[b+1] !== (i8 ^ din_mask)) errs++;
        end
    endtask

    task automatic test_reset();
        bus.ce = 1'b0;
        bus.cpu_addr = 16'h4014;
        bus.cpu_dout = 8'h02;
        bus.cpu_rw = 1'b0;
        tick(1'b1);
        tick(1'b0);
        tests++;
        if ({bus.dma_rdy, bus.dma_active, bus.dma_rw} !== 3'b101) begin
            fails++;
            $display("FAIL reset_ctl: rdy/active/rw=%b required 101", {bus.dma_rdy, bus.dma_active, bus.dma_rw});
        end
        tests++;
        if (bus.dma_addr !== 16'h0000) begin
            fails++;
            $display("FAIL reset_addr: got %h required 0000", bus.dma_addr);
        end
        tests++;
        if (bus.dma_dout !== 8'h00) begin
            fails++;
            $display("FAIL reset_dout: got %h required 00", bus.dma_dout);
        end
        rst = 1'b0;
        ce_total = 0;
        tick(1'b0);
    endtask

    task automatic test_even();
        bit done;
        int errs;
        din_mask = 8'h5A;
        run_transfer(8'h02, 0, 0, 0, 1'b0, done);
        tests++;
        if (done !== 1'b1) begin fails++; $display("FAIL even_done: timeout, rdy=%b required 1", bus.dma_rdy); end
        tests++;
        if (stall !== 513) begin fails++; $display("FAIL even_stall: got %0d required 513", stall); end
        count_txn_errs(8'h02, 0, errs);
        tests++;
        if (errs !== 0) begin fails++; $display("FAIL even_txn: mismatches %0d required 0", errs); end
    endtask

    task automatic test_odd();
        bit done;
        int errs;
        din_mask = 8'hC3;
        run_transfer(8'h02, 1, 0, 0, 1'b0, done);
        tests++;
        if (stall !== 514 || done !== 1'b1) begin fails++; $display("FAIL odd_stall: got %0d done %0d required 514 done 1", stall, done); end
        tests++;
        if (rec_addr[1] !== 16'h0200 || rec_addr[2] !== 16'h2004) begin
            fails++;
            $display("FAIL odd_first_read: got %h,%h required 0200,2004", rec_addr[1], rec_addr[2]);
        end
        count_txn_errs(8'h02, 1, errs);
        tests++;
        if (errs !== 0) begin fails++; $display("FAIL odd_txn: mismatches %0d required 0", errs); end
    endtask

    task automatic test_page_ff();
        bit done;
        int errs;
        din_mask = 8'h00;
        run_transfer(8'hFF, 0, 0, 0, 1'b0, done);
        tests++;
        if (stall !== 513 || done !== 1'b1) begin fails++; $display("FAIL ff_stall: got %0d done %0d required 513 done 1", stall, done); end
        tests++;
        if (rec_dout[$] !== 8'hFF || rec_addr[$] !== 16'h2004) begin
            fails++;
            $display("FAIL ff_last: got %h@%h required FF@2004", rec_dout[$], rec_addr[$]);
        end
        count_txn_errs(8'hFF, 0, errs);
        tests++;
        if (errs !== 0) begin fails++; $display("FAIL ff_txn: mismatches %0d required 0", errs); end
    endtask

    task automatic test_cpu_writes();
        bit done;
        int errs;
        din_mask = 8'h3C;
        run_transfer(8'h10, 0, 2, 0, 1'b0, done);
        tests++;
        if (stall !== 515 || done !== 1'b1) begin fails++; $display("FAIL wr2_even_stall: got %0d required 515", stall); end
        count_txn_errs(8'h10, 0, errs);
        tests++;
        if (errs !== 0) begin fails++; $display("FAIL wr2_even_txn: mismatches %0d required 0", errs); end
        run_transfer(8'h11, 1, 2, 0, 1'b0, done);
        tests++;
        if (stall !== 516 || done !== 1'b1) begin fails++; $display("FAIL wr2_odd_stall: got %0d required 516", stall); end
        count_txn_errs(8'h11, 1, errs);
        tests++;
        if (errs !== 0) begin fails++; $display("FAIL wr2_odd_txn: mismatches %0d required 0", errs); end
    endtask

    task automatic test_gaps();
        bit done;
        int errs;
        din_mask = 8'h96;
        gaps_on = 1'b1;
        freeze_err = 0;
        run_transfer(8'h07, 0, 0, 0, 1'b0, done);
        gaps_on = 1'b0;
        tests++;
        if (stall !== 513 || done !== 1'b1) begin fails++; $display("FAIL gaps_stall: got %0d required 513", stall); end
        count_txn_errs(8'h07, 0, errs);
        tests++;
        if (errs !== 0) begin fails++; $display("FAIL gaps_txn: mismatches %0d required 0", errs); end
        tests++;
        if (freeze_err !== 0) begin fails++; $display("FAIL gaps_freeze: output changes with ce=0 %0d required 0", freeze_err); end
    endtask

    task automatic test_reset_mid();
        bit done;
        int errs;
        din_mask = 8'h21;
        run_transfer(8'h05, 0, 0, 100, 1'b0, done);
        tests++;
        if (wr_count !== 100 || bus.dma_active !== 1'b1) begin
            fails++;
            $display("FAIL rstmid_reach: writes %0d active %b required 100 1", wr_count, bus.dma_active);
        end
        #2 rst = 1'b1;
        #1;
        tests++;
        if ({bus.dma_rdy, bus.dma_active, bus.dma_addr, bus.dma_rw, bus.dma_dout} !== {1'b1, 1'b0, 16'h0000, 1'b1, 8'h00}) begin
            fails++;
            $display("FAIL rstmid_async: rdy %b active %b addr %h rw %b dout %h required 1 0 0000 1 00",
                     bus.dma_rdy, bus.dma_active, bus.dma_addr, bus.dma_rw, bus.dma_dout);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        ce_total = 0;
        snap = {bus.dma_rdy, bus.dma_active, bus.dma_addr, bus.dma_rw, bus.dma_dout};
        run_transfer(8'h03, 1, 0, 0, 1'b0, done);
        tests++;
        if (stall !== 514 || done !== 1'b1) begin fails++; $display("FAIL rstmid_restart_stall: got %0d required 514", stall); end
        count_txn_errs(8'h03, 1, errs);
        tests++;
        if (errs !== 0) begin fails++; $display("FAIL rstmid_restart_txn: mismatches %0d required 0", errs); end
    endtask

    task automatic test_retrigger();
        bit done;
        int busy;
        din_mask = 8'h0F;
        run_transfer(8'h04, 0, 0, 0, 1'b1, done);
        tests++;
        if (stall !== 513 || done !== 1'b1) begin fails++; $display("FAIL retrig_stall: got %0d required 513", stall); end
        busy = 0;
        for (int i = 0; i < 4; i++) begin
            step(16'h8000, 8'h00, 1'b1);
            if (bus.dma_rdy !== 1'b1) busy++;
        end
        tests++;
        if (busy !== 0) begin fails++; $display("FAIL retrig_ignored: halted cycles %0d required 0", busy); end
    endtask

    initial begin
        test_reset();
        test_even();
        test_odd();
        test_page_ff();
        test_cpu_writes();
        test_gaps();
        test_reset_mid();
        test_retrigger();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
